// File: rtl/div_arbiter.sv
//------------------------------------------------------------------------------
// DivArbiter: shares one iterative divider between several requesters.
//
// Requesters raise a level request along with their operands. The arbiter
// picks one owner round-robin and latches its operands. It then either starts
// the divider or answers a zero divisor at once. Finally it returns the
// registered result with a one-cycle ack pulse to the owner.
//
// Ports:
//   Clock          - system clock, rising-edge active
//   nReset         - asynchronous active-low reset
//   req            - per-requester level request, held until ack
//   req_dividend   - packed 32-bit dividends, requester i at [32i+31:32i]
//   req_divisor    - packed 16-bit divisors, requester i at [16i+15:16i]
//   ack            - one-hot one-cycle pulse, result valid for that requester
//   err            - result invalid (divide by zero or divider timeout)
//   quotient       - registered quotient, valid while ack is high
//   remainder      - registered remainder, valid while ack is high
//   div_start      - one-cycle start pulse to the divider
//   div_dividend   - latched dividend presented to the divider
//   div_divisor    - latched divisor presented to the divider
//   div_done       - divider completion pulse
//   div_quotient   - divider quotient, valid with div_done
//   div_remainder  - divider remainder, valid with div_done
//------------------------------------------------------------------------------
module div_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_dividend,
    input  logic [NREQ*16-1:0]   req_divisor,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [31:0]          quotient,
    output logic [15:0]          remainder,
    output logic                 div_start,
    output logic [31:0]          div_dividend,
    output logic [15:0]          div_divisor,
    input  logic                 div_done,
    input  logic [31:0]          div_quotient,
    input  logic [15:0]          div_remainder
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_INIT  = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   rr_idx;
    logic            grant_valid;
    logic [NREQ-1:0] eligible;
    logic            just_acked;
    logic [CW-1:0]   wait_count;
    logic [31:0]     sel_dividend;
    logic [15:0]     sel_divisor;
    logic            zero_div;
    logic            timed_out;

    // Builds a one-hot ack vector for the given requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // The requester that was just acked is kept out of the very next IDLE
    // cycle. A requester that has not yet dropped its level request
    // therefore cannot be granted twice in a row straight away.
    always_comb begin
        eligible = req;
        if (just_acked) begin
            eligible[last] = 1'b0;
        end
    end

    // Round-robin search: start one past the last owner and wrap around.
    // The first eligible requester found wins.
    always_comb begin
        grant       = last;
        grant_valid = 1'b0;
        rr_idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = IW'((int'(last) + k) % NREQ);
            if (!grant_valid && eligible[rr_idx]) begin
                grant       = rr_idx;
                grant_valid = 1'b1;
            end
        end
    end

    // Operand mux for the candidate owner. A plain loop is used here
    // instead of a variable part-select so that every index is a constant.
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IW'(i)) begin
                sel_dividend = req_dividend[i*32 +: 32];
                sel_divisor  = req_divisor[i*16 +: 16];
            end
        end
    end

    assign zero_div  = (sel_divisor == 16'd0);
    assign timed_out = (wait_count == LAST_COUNT);

    // Next-state logic. A zero divisor skips the divider entirely. WAIT
    // leaves on the divider's done pulse or once the wait budget runs out.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = zero_div ? RESP : START;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (div_done || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered datapath and outputs. ack and div_start are computed one
    // edge ahead, so each one is high for exactly the cycle spent in RESP or
    // START, and nothing reaches a port combinationally from req. The
    // result registers are loaded only when entering RESP, so they keep
    // their value until the next transaction completes.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ack          <= '0;
            err          <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            wait_count   <= '0;
            owner        <= '0;
            last         <= LAST_INIT;
            just_acked   <= 1'b0;
        end else begin
            ack        <= '0;
            div_start  <= 1'b0;
            just_acked <= (state == RESP);
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner        <= grant;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        wait_count   <= '0;
                        if (zero_div) begin
                            ack       <= onehot(grant);
                            err       <= 1'b1;
                            quotient  <= '1;
                            remainder <= '1;
                            last      <= grant;
                        end else begin
                            div_start <= 1'b1;
                        end
                    end
                end
                START: begin
                    wait_count <= '0;
                end
                WAIT: begin
                    if (div_done) begin
                        ack       <= onehot(owner);
                        err       <= 1'b0;
                        quotient  <= div_quotient;
                        remainder <= div_remainder;
                        last      <= owner;
                    end else if (timed_out) begin
                        ack       <= onehot(owner);
                        err       <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                        last      <= owner;
                    end else begin
                        wait_count <= wait_count + CW'(1);
                    end
                end
                RESP: begin
                    wait_count <= '0;
                end
                default: begin
                    wait_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
//------------------------------------------------------------------------------
// tb_div_arbiter: directed self-checking bench for div_arbiter.
//
// A small behavioural divider answers div_start after a programmable number
// of cycles (or never). Requesters can be set to drop their request on the
// edge where they see ack. Each scenario task drives its own vectors and
// compares the captured results against hand-computed values.
//------------------------------------------------------------------------------
module tb_div_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 64;

    logic              Clock;
    logic              nReset;
    logic [NREQ-1:0]   req;
    logic [NREQ*32-1:0] req_dividend;
    logic [NREQ*16-1:0] req_divisor;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic [31:0]       quotient;
    logic [15:0]       remainder;
    logic              div_start;
    logic [31:0]       div_dividend;
    logic [15:0]       div_divisor;
    logic              div_done;
    logic [31:0]       div_quotient;
    logic [15:0]       div_remainder;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // divider model state
    int          div_delay = 3;
    int          countdown = 0;
    logic [31:0] op_a;
    logic [15:0] op_b;

    // monitor state
    int              start_count = 0;
    int              start_cycle = -1;
    int              ack_count   = 0;
    bit              auto_drop   = 1'b1;
    logic [NREQ-1:0] drop_mask   = '0;

    // captured response
    bit          got;
    logic [2:0]  got_ack;
    logic [31:0] got_q;
    logic [15:0] got_r;
    logic        got_err;
    int          got_cycle;

    div_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .Clock         (Clock),
        .nReset        (nReset),
        .req           (req),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .ack           (ack),
        .err           (err),
        .quotient      (quotient),
        .remainder     (remainder),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Counts rising edges so latencies can be compared in cycles.
    initial begin
        forever begin
            @(posedge Clock);
            cycle++;
        end
    end

    // Behavioural divider: captures its operands on div_start and raises
    // div_done for one cycle div_delay cycles later; a negative delay means
    // it never answers.
    initial begin
        div_done      = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;
        forever begin
            @(posedge Clock);
            #1;
            div_done = 1'b0;
            if (div_start === 1'b1) begin
                countdown = div_delay;
                op_a      = div_dividend;
                op_b      = div_divisor;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    div_done      = 1'b1;
                    div_quotient  = (op_b != 0) ? op_a / {16'd0, op_b} : 32'd0;
                    div_remainder = (op_b != 0) ? 16'(op_a % {16'd0, op_b}) : 16'd0;
                end
            end
        end
    end

    // Monitor sampled mid-cycle; also records which requesters should drop
    // their request at the edge that ends their ack cycle.
    initial begin
        forever begin
            @(negedge Clock);
            if (div_start === 1'b1) begin
                start_count++;
                start_cycle = cycle;
            end
            if (ack !== '0) begin
                ack_count++;
                if (auto_drop) drop_mask |= ack;
            end
        end
    end

    // Requesters release req just after the edge where ack was high.
    initial begin
        forever begin
            @(posedge Clock);
            #1;
            if (drop_mask != '0) begin
                req       = req & ~drop_mask;
                drop_mask = '0;
            end
        end
    end

    // Hard stop in case something wedges the scenario sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic wait_ack(input int budget);
        got       = 1'b0;
        got_ack   = 'x;
        got_q     = 'x;
        got_r     = 'x;
        got_err   = 1'bx;
        got_cycle = -1;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (ack !== '0) begin
                got       = 1'b1;
                got_ack   = ack;
                got_q     = quotient;
                got_r     = remainder;
                got_err   = err;
                got_cycle = cycle;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_wait: no ack within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        req    = '0;
        step();
        step();
        nReset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        nReset       = 1'b0;
        req          = '0;
        req_dividend = '0;
        req_divisor  = '0;
        step();
        step();
        checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 000", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b expected 0", div_start); end
        checks++; if (quotient !== 32'd0 || remainder !== 16'd0) begin errors++; $display("[TB] FAIL reset_result: got %h/%h expected 0/0", quotient, remainder); end
        checks++; if (div_dividend !== 32'd0 || div_divisor !== 16'd0) begin errors++; $display("[TB] FAIL reset_ops: got %h/%h expected 0/0", div_dividend, div_divisor); end
        nReset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++; if (ack !== 3'b000 || start_count != 0) begin errors++; $display("[TB] FAIL reset_idle: ack %b starts %0d expected 000 and 0", ack, start_count); end
    endtask

    task automatic test_single();
        int req_edge;
        $display("[TB] test_single");
        auto_drop          = 1'b1;
        div_delay          = 3;
        start_count        = 0;
        req_dividend[31:0] = 32'd1000;
        req_divisor[15:0]  = 16'd7;
        req                = 3'b001;
        req_edge           = cycle + 1;
        wait_ack(20);
        checks++; if (got_ack !== 3'b001) begin errors++; $display("[TB] FAIL single_ack: got %b expected 001", got_ack); end
        checks++; if (got_q !== 32'd142) begin errors++; $display("[TB] FAIL single_quotient: got %0d expected 142", got_q); end
        checks++; if (got_r !== 16'd6) begin errors++; $display("[TB] FAIL single_remainder: got %0d expected 6", got_r); end
        checks++; if (got_err !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %b expected 0", got_err); end
        checks++; if (start_cycle != req_edge) begin errors++; $display("[TB] FAIL single_start_latency: got cycle %0d expected %0d", start_cycle, req_edge); end
        checks++; if (got_cycle - start_cycle != 4) begin errors++; $display("[TB] FAIL single_ack_latency: got %0d expected 4", got_cycle - start_cycle); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (start_count != 1) begin errors++; $display("[TB] FAIL single_start_count: got %0d expected 1", start_count); end
        checks++; if (ack !== 3'b000 || quotient !== 32'd142 || remainder !== 16'd6) begin errors++; $display("[TB] FAIL single_hold: ack %b q %0d r %0d expected 000 142 6", ack, quotient, remainder); end
    endtask

    task automatic test_round_robin();
        int req_edge;
        $display("[TB] test_round_robin");
        do_reset();
        auto_drop    = 1'b1;
        div_delay    = 3;
        req_dividend = {32'd50, 32'd200, 32'd100};
        req_divisor  = {16'd3, 16'd7, 16'd10};
        req          = 3'b111;
        wait_ack(20);
        checks++; if (got_ack !== 3'b001 || got_q !== 32'd10 || got_r !== 16'd0) begin errors++; $display("[TB] FAIL rr_first: ack %b q %0d r %0d expected 001 10 0", got_ack, got_q, got_r); end
        wait_ack(20);
        checks++; if (got_ack !== 3'b010 || got_q !== 32'd28 || got_r !== 16'd4) begin errors++; $display("[TB] FAIL rr_second: ack %b q %0d r %0d expected 010 28 4", got_ack, got_q, got_r); end
        wait_ack(20);
        checks++; if (got_ack !== 3'b100 || got_q !== 32'd16 || got_r !== 16'd2) begin errors++; $display("[TB] FAIL rr_third: ack %b q %0d r %0d expected 100 16 2", got_ack, got_q, got_r); end
        step();
        step();
        checks++; if (req !== 3'b000) begin errors++; $display("[TB] FAIL rr_drained: req %b expected 000", req); end
        start_cycle = -1;
        req         = 3'b001;
        req_edge    = cycle + 1;
        wait_ack(20);
        checks++; if (start_cycle != req_edge) begin errors++; $display("[TB] FAIL rr_immediate: start cycle %0d expected %0d", start_cycle, req_edge); end
        checks++; if (got_ack !== 3'b001) begin errors++; $display("[TB] FAIL rr_immediate_ack: got %b expected 001", got_ack); end
        step();
    endtask

    task automatic test_no_regrant();
        int ack_at;
        int restart;
        $display("[TB] test_no_regrant");
        auto_drop          = 1'b0;
        div_delay          = 3;
        req_dividend[31:0] = 32'd1000;
        req_divisor[15:0]  = 16'd7;
        req                = 3'b001;
        wait_ack(20);
        ack_at  = got_cycle;
        restart = -1;
        for (int i = 0; i < 20 && restart < 0; i++) begin
            step();
            if (div_start === 1'b1) restart = cycle;
        end
        checks++; if (restart - ack_at != 3) begin errors++; $display("[TB] FAIL no_regrant_gap: got %0d cycles expected 3", restart - ack_at); end
        req = 3'b000;
        wait_ack(20);
        auto_drop = 1'b1;
        step();
    endtask

    task automatic test_zero_div();
        int req_edge;
        $display("[TB] test_zero_div");
        auto_drop           = 1'b1;
        start_count         = 0;
        req_dividend[63:32] = 32'd77;
        req_divisor[31:16]  = 16'd0;
        req                 = 3'b010;
        req_edge            = cycle + 1;
        wait_ack(10);
        checks++; if (got_ack !== 3'b010) begin errors++; $display("[TB] FAIL zero_ack: got %b expected 010", got_ack); end
        checks++; if (got_cycle != req_edge) begin errors++; $display("[TB] FAIL zero_latency: ack cycle %0d expected %0d", got_cycle, req_edge); end
        checks++; if (got_q !== 32'hFFFF_FFFF || got_r !== 16'hFFFF) begin errors++; $display("[TB] FAIL zero_result: got %h/%h expected ffffffff/ffff", got_q, got_r); end
        checks++; if (got_err !== 1'b1) begin errors++; $display("[TB] FAIL zero_err: got %b expected 1", got_err); end
        step();
        step();
        checks++; if (start_count != 0) begin errors++; $display("[TB] FAIL zero_no_start: got %0d starts expected 0", start_count); end
    endtask

    task automatic test_timeout();
        $display("[TB] test_timeout");
        auto_drop           = 1'b1;
        div_delay           = -1;
        req_dividend[95:64] = 32'd123;
        req_divisor[47:32]  = 16'd5;
        req                 = 3'b100;
        wait_ack(TIMEOUT + 20);
        checks++; if (got_ack !== 3'b100 || got_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_ack: ack %b err %b expected 100 1", got_ack, got_err); end
        checks++; if (got_q !== 32'd0 || got_r !== 16'd0) begin errors++; $display("[TB] FAIL timeout_result: got %h/%h expected 0/0", got_q, got_r); end
        checks++; if (got_cycle - start_cycle != TIMEOUT + 1) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", got_cycle - start_cycle, TIMEOUT + 1); end
        div_delay = 3;
        step();
    endtask

    task automatic test_operand_change();
        int req_edge;
        $display("[TB] test_operand_change");
        auto_drop          = 1'b1;
        div_delay          = 3;
        start_cycle        = -1;
        req_dividend[31:0] = 32'd1000;
        req_divisor[15:0]  = 16'd7;
        req                = 3'b001;
        req_edge           = cycle + 1;
        step();
        step();
        req_dividend[31:0] = 32'd5;
        req                = 3'b000;
        checks++; if (start_cycle != req_edge) begin errors++; $display("[TB] FAIL change_after_idle_start: cycle %0d expected %0d", start_cycle, req_edge); end
        checks++; if (div_dividend !== 32'd1000 || div_divisor !== 16'd7) begin errors++; $display("[TB] FAIL change_latched: got %0d/%0d expected 1000/7", div_dividend, div_divisor); end
        wait_ack(20);
        checks++; if (got_ack !== 3'b001 || got_q !== 32'd142 || got_r !== 16'd6 || got_err !== 1'b0) begin errors++; $display("[TB] FAIL change_result: ack %b q %0d r %0d err %b expected 001 142 6 0", got_ack, got_q, got_r, got_err); end
        step();
    endtask

    task automatic test_reset_in_wait();
        int req_edge;
        int acks_before;
        int starts_before;
        $display("[TB] test_reset_in_wait");
        auto_drop          = 1'b1;
        div_delay          = -1;
        req_dividend[31:0] = 32'd1000;
        req_divisor[15:0]  = 16'd7;
        req                = 3'b001;
        for (int i = 0; i < 3; i++) step();
        nReset = 1'b0;
        req    = 3'b000;
        #1;
        checks++; if (div_divisor !== 16'd0 || div_dividend !== 32'd0 || quotient !== 32'd0) begin errors++; $display("[TB] FAIL async_reset: ops %0d/%0d q %0d expected 0/0/0", div_dividend, div_divisor, quotient); end
        step();
        nReset        = 1'b1;
        acks_before   = ack_count;
        starts_before = start_count;
        div_done      = 1'b1;
        div_quotient  = 32'h1234;
        div_remainder = 16'h0055;
        step();
        div_done = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (ack_count != acks_before || start_count != starts_before) begin errors++; $display("[TB] FAIL late_done: acks %0d starts %0d expected %0d %0d", ack_count, start_count, acks_before, starts_before); end
        div_delay    = 3;
        req_dividend = {32'd0, 32'd200, 32'd1000};
        req_divisor  = {16'd1, 16'd7, 16'd7};
        start_cycle  = -1;
        req          = 3'b011;
        req_edge     = cycle + 1;
        wait_ack(20);
        checks++; if (start_cycle != req_edge) begin errors++; $display("[TB] FAIL post_reset_idle: start cycle %0d expected %0d", start_cycle, req_edge); end
        checks++; if (got_ack !== 3'b001 || got_q !== 32'd142 || got_r !== 16'd6) begin errors++; $display("[TB] FAIL post_reset_first: ack %b q %0d r %0d expected 001 142 6", got_ack, got_q, got_r); end
        wait_ack(20);
        checks++; if (got_ack !== 3'b010 || got_q !== 32'd28 || got_r !== 16'd4) begin errors++; $display("[TB] FAIL post_reset_second: ack %b q %0d r %0d expected 010 28 4", got_ack, got_q, got_r); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_regrant();
        test_zero_div();
        test_timeout();
        test_operand_change();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter NREQ, 3, number of requesters (0 = speedo, 1 = cadence, 2 = trip average).
REQ-002 Parameter TIMEOUT, 64, maximum cycles to wait for div_done before aborting.
REQ-003 Clock  input  1  system clock, all state updates on the rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester level request, held until ack.
REQ-006 req_dividend  input  NREQ*32  packed dividends, requester i at bits [32i+31:32i].
REQ-007 req_divisor  input  NREQ*16  packed divisors, requester i at bits [16i+15:16i].
REQ-008 ack  output  NREQ  one-hot, one-cycle pulse marking the result valid for that requester.
REQ-009 err  output  1  high with ack when the result is invalid (divide by zero or timeout).
REQ-010 quotient  output  32  registered result shared by all requesters, valid while ack is high.
REQ-011 remainder  output  16  registered remainder, valid while ack is high.
REQ-012 div_start  output  1  one-cycle start pulse to the shared iterative divider.
REQ-013 div_dividend, div_divisor  output  32/16  latched operands, stable from div_start until the response.
REQ-014 div_done  input  1  divider completion pulse.
REQ-015 div_quotient, div_remainder  input  32/16  divider results, valid while div_done is high.

Function
REQ-016 FSM states: IDLE, START, WAIT, RESP.
REQ-017 IDLE with no req bit set: remain in IDLE.
REQ-018 IDLE with any req bit set: select the owner round-robin, starting the search at (last+1) mod NREQ and taking the first set bit.
REQ-019 At the IDLE exit edge, latch the owner's dividend and divisor into div_dividend and div_divisor.
REQ-020 Owner divisor non-zero: go to START.
REQ-021 Owner divisor zero: go to RESP with quotient=32'hFFFFFFFF, remainder=16'hFFFF, err=1, and no div_start.
REQ-022 START: div_start=1 for exactly one cycle, then go to WAIT.
REQ-023 WAIT: count cycles from 0.
REQ-024 WAIT, div_done=1: register div_quotient and div_remainder into quotient and remainder, set err=0, and go to RESP.
REQ-025 WAIT, count reaching TIMEOUT-1 without div_done: go to RESP with quotient=0, remainder=0, err=1.
REQ-026 RESP: ack[owner]=1 for one cycle, set last=owner, then return to IDLE.
REQ-027 quotient, remainder and err hold their values after RESP until the next RESP.
REQ-028 Latency without contention: req sampled at edge n gives div_start in cycle n+1, and ack follows one cycle after the edge that samples div_done.
REQ-029 Latency for zero divisor: ack in cycle n+1.
REQ-030 A requester deasserts req at the edge where it samples ack high.
REQ-031 The arbiter never grants a requester again in the IDLE cycle that directly follows that requester's ack.
REQ-032 Operand or req changes after the latch edge are ignored; the operation completes and ack still pulses even if req has dropped.
REQ-033 div_done in any state other than WAIT is ignored.
REQ-034 Simultaneous requests are served one per transaction in rotating order, so no requester waits more than NREQ-1 transactions.
REQ-035 Outputs are only ever driven from registers; there is no combinational path from req to ack or from req to div_start.

Reset
REQ-036 nReset low asynchronously clears: state=IDLE, ack=0, err=0, div_start=0, quotient=0, remainder=0, div_dividend=0, div_divisor=0, wait counter=0.
REQ-037 nReset low sets last=NREQ-1, so requester 0 has highest priority after reset.
REQ-038 Reset during WAIT abandons the operation with no ack; a late div_done after reset is ignored per REQ-033.

Verification
REQ-039 req=001, dividend=1000, divisor=7, div_done three cycles after div_start -> ack=001, quotient=142, remainder=6, err=0; exactly one div_start.
REQ-040 req=111 held with requesters dropping req on ack -> ack order 001, 010, 100; next request from requester 0 alone is served immediately.
REQ-041 req=010, divisor=0 -> ack=010 in the next cycle, quotient=FFFFFFFF, err=1, div_start never asserted.
REQ-042 req=100, divider never asserts div_done -> ack=100 with err=1, quotient=0, TIMEOUT+1 cycles after div_start; arbiter returns to IDLE.
REQ-043 req=001, dividend changed to 5 while in WAIT -> result computed on the originally latched dividend.
REQ-044 nReset pulsed during WAIT, then div_done pulsed -> no ack, state IDLE; a subsequent req=011 grants requester 0 first.
